cam_capture_ds: RTL and testbench
=================================

CAM_CAPTURE_DS -- requirements
Module: cam_capture_ds

Interface
REQ-001 Parameter OUT_FMT, default 0, output format: 0 = RGB565->RGB444, 1 = RGB565 passthrough, 2 = 8-bit gray (YUV422 Y byte).
REQ-002 Parameter DECIM, default 1, decimation factor for both axes; legal values are 1, 2 and 4.
REQ-003 Parameter H_ACTIVE, default 640, pixels per active line.
REQ-004 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-005 Parameter ADDR_W, default 17, write-address width.
REQ-006 pclk  in  1  camera pixel clock; sole clock, all logic on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 vsync  in  1  camera vsync; high = vertical blanking.
REQ-009 href  in  1  camera href; high = active bytes on d.
REQ-010 d  in  8  camera data byte.
REQ-011 enable  in  1  arms capture.
REQ-012 single_shot  in  1  1 = stop after one frame; 0 = capture continuously.
REQ-013 addr  out  ADDR_W  frame-buffer write address.
REQ-014 dout  out  16  pixel data, zero-extended in the MSBs.
REQ-015 we  out  1  write strobe, one cycle per stored pixel.
REQ-016 frame_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-017 line_err  out  1  sticky flag for a malformed line.
REQ-018 busy  out  1  high in SYNC and CAPTURE.

Function
REQ-019 vsync, href and d SHALL be registered once (vsync_q, href_q, d_q) before any use.
REQ-020 The FSM SHALL have states IDLE, SYNC, CAPTURE and HOLD.
- IDLE->SYNC when enable=1.
- SYNC->IDLE when enable=0.
- SYNC->CAPTURE on a vsync_q falling edge.
- CAPTURE->SYNC on a vsync_q rising edge if single_shot=0; CAPTURE->HOLD on that edge if single_shot=1.
- HOLD->IDLE when enable=0.
REQ-021 Entering CAPTURE SHALL clear addr, the pixel x count, the line y count, the byte phase and line_err.
REQ-022 Dropping enable during CAPTURE SHALL NOT abort the frame; the frame completes normally.
REQ-023 While href_q=1, bytes SHALL pair as first byte = MSB and second byte = LSB; the byte phase SHALL reset on each href_q rising edge.
REQ-024 On each completed pair, the pixel SHALL be kept when x%DECIM==0 and y%DECIM==0; x SHALL then increment.
REQ-025 y SHALL increment on each href_q falling edge.
REQ-026 dout SHALL be formed as follows.
- Format 0: {4'h0, p[15:12], p[10:7], p[4:1]}.
- Format 1: p.
- Format 2: {8'h00, first byte}.
REQ-027 For a kept pixel, we SHALL be high for one cycle, two pclk after the second byte is present on d.
REQ-028 dout and addr SHALL be valid in the same cycle as we; addr SHALL increment on the cycle after we.
REQ-029 Writes SHALL stop once addr reaches (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM)-1 has been written: we stays low and addr holds (saturates) until the next CAPTURE entry.
REQ-030 On an href_q falling edge, line_err SHALL set if x != H_ACTIVE or the byte phase is odd; it stays set until the next CAPTURE entry.
REQ-031 frame_done SHALL pulse for one cycle on the CAPTURE exit edge; it SHALL NOT pulse in other states.
REQ-032 Lines arriving beyond V_ACTIVE SHALL be ignored; they SHALL NOT set line_err.

Reset
REQ-033 While rst_n=0, the block SHALL be in IDLE with addr=0, dout=0, we=0, frame_done=0, line_err=0, busy=0, all counters 0 and input registers 0.
REQ-034 Reset asserted mid-frame SHALL take effect immediately, with no further we pulse.
REQ-035 After reset release, capture SHALL restart only from a new vsync_q falling edge.

Structure
REQ-036 A shared package cam_pkg SHALL hold the OUT_FMT encodings, the FSM state encoding and a function that computes the pixel-count limit.
REQ-037 One sub-module, cam_byte_pack, SHALL implement byte pairing and format conversion; the top level holds the FSM, counters, decimation and address logic.

Verification
REQ-038 Format 0, H_ACTIVE=8, V_ACTIVE=4, DECIM=1, pair 0xF8,0x1F -> dout=0x0F0F; 32 writes at addr 0..31; frame_done pulses once.
REQ-039 Format 2, pair 0x80,0x33 -> dout=0x0080.
REQ-040 DECIM=2 on an 8x4 frame -> exactly 8 writes at addr 0..7, every kept pixel having even x and even y.
REQ-041 A line with href high for only 6 pixels (H_ACTIVE=8) -> line_err=1 after that line, cleared on the next frame start.
REQ-042 A frame with 6 lines (V_ACTIVE=4) -> addr saturates at 31, no extra we, line_err=0.
REQ-043 rst_n pulsed low mid-line -> outputs zero immediately; with single_shot=1, a second frame after frame_done produces no we.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture / downscale block.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package cam_pkg;

    // Output pixel formats
    localparam int FMT_RGB444 = 0;   // RGB565 reduced to RGB444
    localparam int FMT_RGB565 = 1;   // RGB565 passed through
    localparam int FMT_GRAY   = 2;   // 8-bit gray taken from the first (Y) byte

    // Capture controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } cap_state_t;

    // One camera pixel as it arrives on the byte bus: first byte is the MSB
    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
    } pix_pair_t;

    // Index of the last frame-buffer word for a given geometry and decimation
    function automatic int pix_limit(input int h_active, input int v_active, input int decim);
        return (h_active / decim) * (v_active / decim) - 1;
    endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// Pairs camera bytes into 16-bit pixels and converts them to the output format.
// Latency: combinational pair strobe in the cycle the second byte sits in d_q.
// Backpressure: none; the camera cannot be stalled, pixels are offered once.
//
// Ports:
//   pclk, rst_n  clock and asynchronous active-low reset
//   clr          clears the byte phase (start of a captured frame)
//   href_q       registered href; bytes are only paired while it is high
//   href_rise    href_q rising edge; the byte in d_q is then a first byte
//   d_q          registered camera byte
//   pair_vld     a pixel pair completes this cycle
//   pair_dat     the completed pixel in the selected output format
//   phase_odd    a first byte was seen without its partner
module cam_byte_pack
    import cam_pkg::*;
#(
    parameter int OUT_FMT = FMT_RGB444
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        href_q,
    input  logic        href_rise,
    input  logic [7:0]  d_q,
    output logic        pair_vld,
    output logic [15:0] pair_dat,
    output logic        phase_odd
);

    logic      phase;
    logic      eff_phase;
    logic [7:0] msb_byte;
    pix_pair_t pix;

    // A new line always starts on a first byte, whatever the stale phase says.
    always_comb begin
        eff_phase = href_rise ? 1'b0 : phase;
        pair_vld  = href_q & eff_phase;
        pix.hi    = msb_byte;
        pix.lo    = d_q;
        phase_odd = phase;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= 1'b0;
            msb_byte <= 8'h00;
        end else if (clr) begin
            phase    <= 1'b0;
        end else if (href_q) begin
            phase <= ~eff_phase;
            if (!eff_phase) begin
                msb_byte <= d_q;
            end
        end
    end

    always_comb begin
        case (OUT_FMT)
            FMT_RGB565: pair_dat = pix;
            FMT_GRAY:   pair_dat = {8'h00, pix.hi};
            default:    pair_dat = {4'h0, pix[15:12], pix[10:7], pix[4:1]};
        endcase
    end

endmodule

// File: rtl/cam_capture_ds.sv
// Camera capture with optional 1/2/4 decimation, writing pixels to a frame buffer.
// Latency: we/dout/addr appear two pclk after the second byte of a pixel is on d.
// Backpressure: none; the frame buffer must accept one write per kept pixel.
//
// Ports:
//   pclk, rst_n         pixel clock, asynchronous active-low reset
//   vsync, href, d      raw camera interface (registered once before use)
//   enable              arms capture; dropping it mid-frame lets the frame finish
//   single_shot         1 = park in HOLD after one frame
//   addr, dout, we      frame-buffer write port; addr advances after each write
//   frame_done          one-cycle pulse when a captured frame ends
//   line_err            sticky: a line had the wrong pixel count or an odd byte count
//   busy                waiting for or capturing a frame
module cam_capture_ds
    import cam_pkg::*;
#(
    parameter int OUT_FMT  = 0,
    parameter int DECIM    = 1,    // 1, 2 or 4 only; the keep test masks low bits
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 17
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              enable,
    input  logic              single_shot,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic              line_err,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(pix_limit(H_ACTIVE, V_ACTIVE, DECIM));
    localparam logic [15:0]       H_LIM      = 16'(H_ACTIVE);
    localparam logic [15:0]       V_LIM      = 16'(V_ACTIVE);
    localparam logic [15:0]       DEC_MASK   = 16'(DECIM - 1);
    localparam logic [15:0]       CNT_MAX    = 16'hFFFF;

    // Input registers plus one more stage for edge detection
    logic       vsync_q, vsync_qq;
    logic       href_q, href_qq;
    logic [7:0] d_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
            href_q   <= 1'b0;
            href_qq  <= 1'b0;
            d_q      <= 8'h00;
        end else begin
            vsync_q  <= vsync;
            vsync_qq <= vsync_q;
            href_q   <= href;
            href_qq  <= href_q;
            d_q      <= d;
        end
    end

    logic vs_rise, vs_fall, href_rise, href_fall;

    assign vs_rise   =  vsync_q & ~vsync_qq;
    assign vs_fall   = ~vsync_q &  vsync_qq;
    assign href_rise =  href_q  & ~href_qq;
    assign href_fall = ~href_q  &  href_qq;

    // ---------------- Controller ----------------
    cap_state_t state, state_nxt;
    logic       cap_entry;
    logic       capturing;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // enable is only looked at outside CAPTURE so a started frame always completes
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (!enable)      state_nxt = ST_IDLE;
                else if (vs_fall) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (vs_rise) state_nxt = single_shot ? ST_HOLD : ST_SYNC;
            end
            ST_HOLD: begin
                if (!enable) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == ST_SYNC) || (state == ST_CAPTURE);
        capturing  = (state == ST_CAPTURE);
        frame_done = capturing && vs_rise;
        cap_entry  = (state == ST_SYNC) && enable && vs_fall;
    end

    // ---------------- Byte pairing ----------------
    logic        pair_vld;
    logic [15:0] pair_dat;
    logic        phase_odd;

    cam_byte_pack #(
        .OUT_FMT (OUT_FMT)
    ) u_byte_pack (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .clr       (cap_entry),
        .href_q    (href_q),
        .href_rise (href_rise),
        .d_q       (d_q),
        .pair_vld  (pair_vld),
        .pair_dat  (pair_dat),
        .phase_odd (phase_odd)
    );

    // ---------------- Counters, decimation, address ----------------
    logic [15:0] x_cnt, y_cnt;
    logic        full;       // last buffer word written; no more writes this frame
    logic        in_frame;
    logic        keep;

    always_comb begin
        in_frame = (y_cnt < V_LIM);
        keep     = ((x_cnt & DEC_MASK) == 16'd0) &&
                   ((y_cnt & DEC_MASK) == 16'd0) &&
                   (x_cnt < H_LIM) && in_frame && !full;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            dout     <= 16'h0000;
            we       <= 1'b0;
            line_err <= 1'b0;
            x_cnt    <= 16'd0;
            y_cnt    <= 16'd0;
            full     <= 1'b0;
        end else begin
            we <= 1'b0;
            if (cap_entry) begin
                addr     <= '0;
                line_err <= 1'b0;
                x_cnt    <= 16'd0;
                y_cnt    <= 16'd0;
                full     <= 1'b0;
            end else begin
                // Address moves on after the write it belonged to, and sticks at the end
                if (we) begin
                    if (addr == ADDR_LIMIT) full <= 1'b1;
                    else                    addr <= addr + 1'b1;
                end
                if (capturing) begin
                    if (href_rise) begin
                        x_cnt <= 16'd0;
                    end else if (pair_vld && (x_cnt != CNT_MAX)) begin
                        x_cnt <= x_cnt + 16'd1;
                    end
                    if (href_fall) begin
                        // Lines past the bottom of the frame are not judged
                        if (in_frame && ((x_cnt != H_LIM) || phase_odd)) begin
                            line_err <= 1'b1;
                        end
                        if (y_cnt != CNT_MAX) y_cnt <= y_cnt + 16'd1;
                    end
                    if (pair_vld && keep) begin
                        we   <= 1'b1;
                        dout <= pair_dat;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ds.sv
// Directed bench for cam_capture_ds: three instances on one camera stream.
// u0: RGB444, DECIM 1; u1: gray, DECIM 1; u2: passthrough, DECIM 2; all 8x4.
// Writes are logged at negedge; expectations are hand-computed constants.
module tb_cam_capture_ds;

    logic       pclk = 1'b0;
    logic       rst_n, vsync, href, enable, single_shot;
    logic [7:0] d;

    always #5 pclk = ~pclk;

    logic [16:0] addr0, addr1, addr2;
    logic [15:0] dout0, dout1, dout2;
    logic        we0, we1, we2, fd0, fd1, fd2, le0, le1, le2, busy0, busy1, busy2;

    cam_capture_ds #(.OUT_FMT(0), .DECIM(1), .H_ACTIVE(8), .V_ACTIVE(4), .ADDR_W(17)) u0 (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .enable(enable),
        .single_shot(single_shot), .addr(addr0), .dout(dout0), .we(we0),
        .frame_done(fd0), .line_err(le0), .busy(busy0));

    cam_capture_ds #(.OUT_FMT(2), .DECIM(1), .H_ACTIVE(8), .V_ACTIVE(4), .ADDR_W(17)) u1 (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .enable(enable),
        .single_shot(single_shot), .addr(addr1), .dout(dout1), .we(we1),
        .frame_done(fd1), .line_err(le1), .busy(busy1));

    cam_capture_ds #(.OUT_FMT(1), .DECIM(2), .H_ACTIVE(8), .V_ACTIVE(4), .ADDR_W(17)) u2 (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .enable(enable),
        .single_shot(single_shot), .addr(addr2), .dout(dout2), .we(we2),
        .frame_done(fd2), .line_err(le2), .busy(busy2));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write log
    int          wr0 = 0, wr1 = 0, wr2 = 0;
    int          abad0 = 0, abad1 = 0, abad2 = 0;
    int          fdn0 = 0;
    logic [15:0] dq0[$], dq1[$], dq2[$];

    always @(negedge pclk) begin
        if (we0) begin
            if (addr0 != 17'(wr0)) abad0 = abad0 + 1;
            dq0.push_back(dout0);
            wr0 = wr0 + 1;
        end
        if (we1) begin
            if (addr1 != 17'(wr1)) abad1 = abad1 + 1;
            dq1.push_back(dout1);
            wr1 = wr1 + 1;
        end
        if (we2) begin
            if (addr2 != 17'(wr2)) abad2 = abad2 + 1;
            dq2.push_back(dout2);
            wr2 = wr2 + 1;
        end
        if (fd0) fdn0 = fdn0 + 1;
    end

    task automatic clear_mon();
        wr0 = 0; wr1 = 0; wr2 = 0;
        abad0 = 0; abad1 = 0; abad2 = 0;
        fdn0 = 0;
        dq0.delete(); dq1.delete(); dq2.delete();
    endtask

    logic [7:0] fb0, fb1;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_line(input int npix, input int yy, input bit pat);
        href = 1'b1;
        for (int px = 0; px < npix; px++) begin
            d = pat ? {yy[3:0], px[3:0]} : fb0;
            tick();
            d = pat ? 8'h33 : fb1;
            tick();
        end
        href = 1'b0;
        d    = 8'h00;
        repeat (4) tick();
    endtask

    task automatic frame_begin();
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_frame(input int nlines, input int short_y, input bit pat);
        frame_begin();
        for (int y = 0; y < nlines; y++) send_line((y == short_y) ? 6 : 8, y, pat);
        frame_end();
    endtask

    initial begin
        int bad;
        int wr_at_rst;

        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; d = 8'h00;
        enable = 1'b0; single_shot = 1'b0; fb0 = 8'h00; fb1 = 8'h00;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_addr",  addr0, 0);
        check("rst_dout",  dout0, 0);
        check("rst_we",    we0,   0);
        check("rst_fd",    fd0,   0);
        check("rst_lerr",  le0,   0);
        check("rst_busy",  busy0, 0);

        rst_n = 1'b1;
        tick();
        enable = 1'b1;
        repeat (3) tick();
        check("busy_sync", busy0, 1);

        // 0xF8,0x1F in RGB444 -> 0x0F0F, full 8x4 frame
        fb0 = 8'hF8; fb1 = 8'h1F;
        clear_mon();
        send_frame(4, -1, 1'b0);
        check("f444_writes", wr0, 32);
        check("f444_addrseq", abad0, 0);
        check("f444_lastaddr", addr0, 31);
        check("f444_fdone", fdn0, 1);
        check("f444_lerr", le0, 0);
        bad = 0;
        foreach (dq0[k]) if (dq0[k] !== 16'h0F0F) bad++;
        check("f444_dout", bad, 0);
        check("d2_writes", wr2, 8);
        check("d2_addrseq", abad2, 0);

        // Coordinate-tagged pixels: u2 must keep only even x and even y
        clear_mon();
        send_frame(4, -1, 1'b1);
        check("d2p_writes", wr2, 8);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            logic [15:0] exp_px;
            exp_px = {4'(2 * (k / 4)), 4'(2 * (k % 4)), 8'h33};
            if (k >= dq2.size() || dq2[k] !== exp_px) bad++;
        end
        check("d2p_pixels", bad, 0);

        // 0x80,0x33: gray -> 0x0080, RGB444 -> 0x0809
        fb0 = 8'h80; fb1 = 8'h33;
        clear_mon();
        send_frame(4, -1, 1'b0);
        check("gray_writes", wr1, 32);
        check("gray_addrseq", abad1, 0);
        bad = 0;
        foreach (dq1[k]) if (dq1[k] !== 16'h0080) bad++;
        check("gray_dout", bad, 0);
        bad = 0;
        foreach (dq0[k]) if (dq0[k] !== 16'h0809) bad++;
        check("f444b_dout", bad, 0);

        // Short line sets line_err
        clear_mon();
        send_frame(4, 1, 1'b0);
        check("short_lerr", le0, 1);

        // Next frame start clears it; this frame carries 6 lines
        clear_mon();
        frame_begin();
        check("lerr_cleared", le0, 0);
        for (int y = 0; y < 6; y++) send_line(8, y, 1'b0);
        frame_end();
        check("tall_writes", wr0, 32);
        check("tall_addrseq", abad0, 0);
        check("tall_lastaddr", addr0, 31);
        check("tall_lerr", le0, 0);
        check("tall_fdone", fdn0, 1);

        // Reset in the middle of a line
        clear_mon();
        frame_begin();
        href = 1'b1;
        for (int px = 0; px < 3; px++) begin
            d = fb0; tick();
            d = fb1; tick();
        end
        d = fb0;
        check("pre_rst_addr", addr0, 2);
        rst_n = 1'b0;
        #1;
        wr_at_rst = wr0;
        check("mid_rst_we", we0, 0);
        check("mid_rst_addr", addr0, 0);
        check("mid_rst_dout", dout0, 0);
        check("mid_rst_busy", busy0, 0);
        for (int px = 0; px < 4; px++) begin
            d = fb1; tick();
            d = fb0; tick();
        end
        href = 1'b0;
        d = 8'h00;
        repeat (4) tick();
        check("in_rst_no_we", wr0, wr_at_rst);

        // After release capture waits for a fresh vsync falling edge
        rst_n = 1'b1;
        repeat (2) tick();
        send_line(8, 0, 1'b0);
        check("post_rst_no_we", wr0, wr_at_rst);
        check("post_rst_busy", busy0, 1);

        // Single shot: one frame, then parked
        single_shot = 1'b1;
        clear_mon();
        send_frame(4, -1, 1'b0);
        check("ss_writes", wr0, 32);
        check("ss_fdone", fdn0, 1);
        check("ss_hold_busy", busy0, 0);
        clear_mon();
        send_frame(4, -1, 1'b0);
        check("ss2_writes", wr0, 0);
        check("ss2_fdone", fdn0, 0);

        enable = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
